// File: rtl/frog_collision_tracker.sv
// Frog/car collision detection plus lives, score, grace period and level-up
// bookkeeping; drives the lane direction pattern back to the movement block.
module frog_collision_tracker #(
    parameter int unsigned TILE_SIZE        = 32,
    parameter int unsigned c_NB_CARS        = 4,
    parameter int unsigned NUM_BITS         = 4,
    parameter int unsigned c_FIRST_LANE_ROW = 2,
    parameter int unsigned c_GOAL_ROW       = 0,
    parameter int unsigned c_LIVES          = 3,
    parameter int unsigned c_GRACE_CYCLES   = 25_000_000
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic [9:0]          i_Car_X_0,
    input  logic [9:0]          i_Car_X_1,
    input  logic [9:0]          i_Car_X_2,
    input  logic [9:0]          i_Car_X_3,
    input  logic [9:0]          i_Frog_X,
    input  logic [3:0]          i_Frog_Row,
    input  logic                i_Restart,
    output logic                o_Hit,
    output logic                o_Level_Up,
    output logic [1:0]          o_Lives,
    output logic [6:0]          o_Score,
    output logic                o_Game_Over,
    output logic [NUM_BITS-1:0] o_Reverse
);

    localparam int unsigned IDX_W     = 2;
    localparam int unsigned SUM_W     = 11;
    localparam int unsigned GRACE_W   = (c_GRACE_CYCLES > 1) ? $clog2(c_GRACE_CYCLES) : 1;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    localparam logic [6:0]  SCORE_MAX = 7'd127;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_GRACE,
        ST_OVER
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [GRACE_W-1:0]   grace_q, grace_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic                 goal_prev_q, goal_prev_d;
    logic                 hit_q, hit_d;
    logic                 level_up_q, level_up_d;
    logic [1:0]           lives_q, lives_d;
    logic [6:0]           score_q, score_d;
    logic                 game_over_q, game_over_d;
    logic [NUM_BITS-1:0]  reverse_q, reverse_d;

    logic [9:0]           car_x_c;
    logic [3:0]           lane_row_c;
    logic                 overlap_c;
    logic                 goal_now_c;
    logic                 goal_rise_c;
    logic [7:0]           lfsr_step_c;
    logic [IDX_W-1:0]     idx_next_c;

    // Select the car under test this cycle.
    always_comb begin
        car_x_c = i_Car_X_0;
        case (idx_q)
            2'd1:    car_x_c = i_Car_X_1;
            2'd2:    car_x_c = i_Car_X_2;
            2'd3:    car_x_c = i_Car_X_3;
            default: car_x_c = i_Car_X_0;
        endcase
    end

    // Strict overlap in 11 bits so X + TILE_SIZE never wraps; touching edges miss.
    always_comb begin
        lane_row_c = 4'(c_FIRST_LANE_ROW) + 4'(idx_q);
        overlap_c  = (i_Frog_Row == lane_row_c)
                  && ({1'b0, i_Frog_X} < ({1'b0, car_x_c} + SUM_W'(TILE_SIZE)))
                  && ({1'b0, car_x_c} < ({1'b0, i_Frog_X} + SUM_W'(TILE_SIZE)));
        goal_now_c  = (i_Frog_Row == 4'(c_GOAL_ROW));
        goal_rise_c = goal_now_c & ~goal_prev_q;
        lfsr_step_c = {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3])};
        idx_next_c  = (idx_q == IDX_W'(c_NB_CARS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_next_c;
        grace_d     = grace_q;
        lfsr_d      = lfsr_q;
        goal_prev_d = goal_now_c;
        hit_d       = 1'b0;
        level_up_d  = 1'b0;
        lives_d     = lives_q;
        score_d     = score_q;
        reverse_d   = reverse_q;

        case (state_q)
            ST_PLAY: begin
                if (overlap_c) begin
                    hit_d = 1'b1;
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = ST_OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        grace_d = GRACE_W'(c_GRACE_CYCLES - 1);
                        state_d = ST_GRACE;
                    end
                end
            end
            ST_GRACE: begin
                if (grace_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    grace_d = grace_q - GRACE_W'(1);
                end
            end
            ST_OVER: begin
                if (i_Restart) begin
                    state_d   = ST_PLAY;
                    lives_d   = 2'(c_LIVES);
                    score_d   = '0;
                    lfsr_d    = LFSR_SEED;
                    reverse_d = '0;
                    idx_d     = '0;
                end
            end
            default: state_d = ST_PLAY;
        endcase

        // Goal handling is independent of hit handling in the same cycle.
        if ((state_q != ST_OVER) && goal_rise_c) begin
            level_up_d = 1'b1;
            score_d    = (score_q == SCORE_MAX) ? score_q : score_q + 7'd1;
            lfsr_d     = lfsr_step_c;
            reverse_d  = lfsr_step_c[NUM_BITS-1:0];
        end

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= ST_PLAY;
            idx_q       <= '0;
            grace_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            goal_prev_q <= 1'b1;
            hit_q       <= 1'b0;
            level_up_q  <= 1'b0;
            lives_q     <= 2'(c_LIVES);
            score_q     <= '0;
            game_over_q <= 1'b0;
            reverse_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            grace_q     <= grace_d;
            lfsr_q      <= lfsr_d;
            goal_prev_q <= goal_prev_d;
            hit_q       <= hit_d;
            level_up_q  <= level_up_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            reverse_q   <= reverse_d;
        end
    end

    assign o_Hit       = hit_q;
    assign o_Level_Up  = level_up_q;
    assign o_Lives     = lives_q;
    assign o_Score     = score_q;
    assign o_Game_Over = game_over_q;
    assign o_Reverse   = reverse_q;

endmodule

// File: tb/tb_frog_collision_tracker.sv
// Randomized and directed bench for frog_collision_tracker against a
// behavioural game model kept in plain integers.
module tb_frog_collision_tracker;

    localparam int GRACE = 8;
    localparam int NCARS = 4;
    localparam int TILE  = 32;
    localparam int LIVES = 3;

    localparam int M_PLAY  = 0;
    localparam int M_GRACE = 1;
    localparam int M_OVER  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] car0 = '0, car1 = '0, car2 = '0, car3 = '0;
    logic [9:0] frog_x = '0;
    logic [3:0] frog_row = 4'd1;
    logic       restart = 1'b0;
    logic       hit, level_up, game_over;
    logic [1:0] lives;
    logic [6:0] score;
    logic [3:0] reverse;

    int checks = 0;
    int failures = 0;

    // Model state: game mode, lives, score, remaining grace clocks, scanned car.
    int m_mode, m_lives, m_score, m_left, m_car, m_lfsr, m_on_goal_before;
    int m_hit, m_lu, m_rev;

    frog_collision_tracker #(
        .TILE_SIZE(TILE), .c_NB_CARS(NCARS), .NUM_BITS(4), .c_FIRST_LANE_ROW(2),
        .c_GOAL_ROW(0), .c_LIVES(LIVES), .c_GRACE_CYCLES(GRACE)
    ) dut (
        .i_Clk(clk), .i_Reset(rst),
        .i_Car_X_0(car0), .i_Car_X_1(car1), .i_Car_X_2(car2), .i_Car_X_3(car3),
        .i_Frog_X(frog_x), .i_Frog_Row(frog_row), .i_Restart(restart),
        .o_Hit(hit), .o_Level_Up(level_up), .o_Lives(lives), .o_Score(score),
        .o_Game_Over(game_over), .o_Reverse(reverse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int car_pos(input int k);
        case (k)
            0: return int'(car0);
            1: return int'(car1);
            2: return int'(car2);
            default: return int'(car3);
        endcase
    endfunction

    // Xilinx-style XNOR LFSR, taps 8,6,5,4 (bit numbers 1..8).
    function automatic int lfsr_next(input int v);
        int ones;
        ones = ((v >> 7) & 1) + ((v >> 5) & 1) + ((v >> 4) & 1) + ((v >> 3) & 1);
        return ((v * 2) % 256) + (((ones % 2) == 0) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_mode = M_PLAY; m_lives = LIVES; m_score = 0; m_left = 0; m_car = 0;
        m_lfsr = 8'hA5; m_on_goal_before = 1; m_hit = 0; m_lu = 0; m_rev = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int cx, fx, old_mode;
        bit touching, goal_entry, on_goal;
        if (rst) begin
            model_reset();
            return;
        end
        cx = car_pos(m_car);
        fx = int'(frog_x);
        touching = (int'(frog_row) == 2 + m_car) && (fx < cx + TILE) && (cx < fx + TILE);
        on_goal = (frog_row == 4'd0);
        goal_entry = on_goal && (m_on_goal_before == 0);
        old_mode = m_mode;
        m_hit = 0;
        m_lu = 0;
        m_car = (m_car + 1) % NCARS;
        if (old_mode == M_PLAY && touching) begin
            m_hit = 1;
            m_lives = m_lives - 1;
            if (m_lives == 0) m_mode = M_OVER;
            else begin
                m_mode = M_GRACE;
                m_left = GRACE;
            end
        end else if (old_mode == M_GRACE) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_PLAY;
        end else if (old_mode == M_OVER && restart) begin
            m_mode = M_PLAY; m_lives = LIVES; m_score = 0; m_lfsr = 8'hA5;
            m_rev = 0; m_car = 0;
        end
        if (old_mode != M_OVER && goal_entry) begin
            m_lu = 1;
            if (m_score < 127) m_score = m_score + 1;
            m_lfsr = lfsr_next(m_lfsr);
            m_rev = m_lfsr % 16;
        end
        m_on_goal_before = on_goal ? 1 : 0;
    endtask

    int hits_seen, lu_seen;

    // One clock: predict, clock, compare every output.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("hit", int'(hit), m_hit);
        check("level_up", int'(level_up), m_lu);
        check("lives", int'(lives), m_lives);
        check("score", int'(score), m_score);
        check("game_over", int'(game_over), (m_mode == M_OVER) ? 1 : 0);
        check("reverse", int'(reverse), m_rev);
        if (hit) hits_seen++;
        if (level_up) lu_seen++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_hit(input string tag, input int budget);
        int start;
        start = hits_seen;
        for (int i = 0; i < budget && hits_seen == start; i++) step();
        check(tag, hits_seen - start, 1);
    endtask

    initial begin
        model_reset();
        hits_seen = 0;
        lu_seen = 0;
        car0 = 10'd600; car1 = 10'd600; car2 = 10'd600; car3 = 10'd600;
        frog_x = 10'd100; frog_row = 4'd1;
        do_reset();
        check("rst_lives", int'(lives), 3);
        check("rst_score", int'(score), 0);
        check("rst_over", int'(game_over), 0);

        // Single hit, grace, second hit.
        car0 = 10'd90; frog_row = 4'd2;
        wait_hit("first_hit", 4);
        check("lives_after_1", int'(lives), 2);
        hits_seen = 0;
        repeat (GRACE) step();
        check("grace_no_hit", hits_seen, 0);
        wait_hit("second_hit", 4);
        check("lives_after_2", int'(lives), 1);

        // Touching edge vs one-pixel overlap on lane 1.
        frog_row = 4'd1;
        do_reset();
        car0 = 10'd600; car1 = 10'd132; frog_x = 10'd100; frog_row = 4'd3;
        hits_seen = 0;
        repeat (8) step();
        check("touch_edge", hits_seen, 0);
        car1 = 10'd131;
        wait_hit("overlap_131", 4);

        // Game over and restart.
        frog_row = 4'd1;
        do_reset();
        car0 = 10'd90; car1 = 10'd600; frog_row = 4'd2;
        hits_seen = 0;
        repeat (40) step();
        check("three_hits", hits_seen, 3);
        check("over_lives", int'(lives), 0);
        check("over_flag", int'(game_over), 1);
        hits_seen = 0;
        repeat (10) step();
        check("over_no_hit", hits_seen, 0);
        restart = 1'b1;
        frog_row = 4'd1;
        step();
        restart = 1'b0;
        check("restart_lives", int'(lives), 3);
        check("restart_over", int'(game_over), 0);
        check("restart_rev", int'(reverse), 0);

        // Goal: one pulse while held, LFSR A5 -> 4B.
        car0 = 10'd600;
        frog_row = 4'd5;
        repeat (3) step();
        frog_row = 4'd0;
        lu_seen = 0;
        repeat (100) step();
        check("goal_pulses", lu_seen, 1);
        check("goal_score", int'(score), 1);
        check("goal_rev", int'(reverse), 4'hB);
        frog_row = 4'd1; step();
        frog_row = 4'd0; step(); step();
        check("goal_score2", int'(score), 2);

        // Saturation.
        for (int i = 0; i < 130; i++) begin
            frog_row = 4'd1; step();
            frog_row = 4'd0; step();
        end
        check("score_sat", int'(score), 127);

        // Reset coincident with a pending hit.
        frog_row = 4'(2 + m_car);
        car0 = 10'd90; car1 = 10'd90; car2 = 10'd90; car3 = 10'd90;
        rst = 1'b1;
        step();
        check("rst_hit", int'(hit), 0);
        check("rst_hit_lives", int'(lives), 3);
        check("rst_hit_score", int'(score), 0);
        rst = 1'b0;

        // Randomized play.
        for (int n = 0; n < 800; n++) begin
            int sel, k, fx, hold;
            car0 = 10'($urandom_range(0, 700));
            car1 = 10'($urandom_range(0, 700));
            car2 = 10'($urandom_range(0, 700));
            car3 = 10'($urandom_range(0, 700));
            sel = int'($urandom % 8);
            if (sel <= 5) frog_row = 4'(sel);
            else frog_row = 4'($urandom % 16);
            k = int'($urandom % 4);
            fx = car_pos(k) + int'($urandom_range(0, 80)) - 40;
            if (fx < 0) fx = 0;
            frog_x = 10'(fx);
            hold = int'($urandom_range(1, 6));
            for (int h = 0; h < hold; h++) begin
                restart = (($urandom % 12) == 0);
                rst = (($urandom % 600) == 0);
                step();
            end
        end
        rst = 1'b0;
        restart = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frog_collision_tracker.md
# frog_collision_tracker

Consumes the car X positions produced by the obstacle movement block and the frog's position. It detects frog/car overlap and keeps the lives and score state. It closes the loop back to the movement block by driving its `i_Score`, `i_Level_Up` and `i_Reverse` inputs. It sits between the frog controller and the obstacle generator, and feeds the HUD and renderer.

## Interface
Parameters:
- `TILE_SIZE`, 32: sprite width/height in pixels; overlap window.
- `c_NB_CARS`, 4: number of active lanes/cars scanned (1..4).
- `NUM_BITS`, 4: width of `o_Reverse`.
- `c_FIRST_LANE_ROW`, 2: tile row of lane 0. Lane k is row `c_FIRST_LANE_ROW + k`. Must be ≥1.
- `c_GOAL_ROW`, 0: tile row that scores a level.
- `c_LIVES`, 3: lives at reset/restart (1..3).
- `c_GRACE_CYCLES`, 25_000_000: invulnerability length after a hit (1 s at 25 MHz).

Ports:
- `i_Clk`  in  1  system clock.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Car_X_0`..`i_Car_X_3`  in  10 each  car left-edge X, pixels.
- `i_Frog_X`  in  10  frog left-edge X, pixels.
- `i_Frog_Row`  in  4  frog tile row.
- `i_Restart`  in  1  level-sensitive restart request; honoured only in OVER.
- `o_Hit`  out  1  one-cycle pulse per accepted collision.
- `o_Level_Up`  out  1  one-cycle pulse when the goal is reached.
- `o_Lives`  out  2  remaining lives.
- `o_Score`  out  7  levels cleared, saturating at 127.
- `o_Game_Over`  out  1  high while in OVER.
- `o_Reverse`  out  `NUM_BITS`  per-lane direction pattern for the movement block.

## Operation
- **States:** PLAY, GRACE, OVER.
- **Scan:**
  - Index `r_Idx` cycles 0..`c_NB_CARS`-1, one car per clock, then wraps to 0.
  - The scan runs in every state.
- **Overlap test for car k:** `i_Frog_Row == c_FIRST_LANE_ROW + k` AND `i_Frog_X < car_X + TILE_SIZE` AND `car_X < i_Frog_X + TILE_SIZE`.
  - Sums are evaluated in 11 bits, so there is no wrap.
  - Touching edges (difference exactly `TILE_SIZE`) do not overlap.
- **PLAY, overlap found:**
  - `o_Hit` pulses and `o_Lives` decrements.
  - If lives were 1: `o_Lives`=0, go to OVER.
  - Otherwise: load the grace counter with `c_GRACE_CYCLES`-1 and go to GRACE.
- **GRACE:**
  - Overlaps are ignored.
  - The counter decrements each clock; the state returns to PLAY on the clock after the counter reads 0.
- **OVER:**
  - Overlaps and goals are ignored. `o_Game_Over`=1.
  - `i_Restart`=1 → PLAY: `o_Lives`=`c_LIVES`, `o_Score`=0, LFSR reseeded, `o_Reverse`=0, `r_Idx`=0.
- **Goal:**
  - Detected on the rising edge of (`i_Frog_Row == c_GOAL_ROW`), using a registered previous value, in PLAY or GRACE.
  - On detection: `o_Level_Up` pulses and `o_Score` increments, saturating at 127.
  - The LFSR steps once and `o_Reverse` loads `lfsr_next[NUM_BITS-1:0]`.
  - Holding the frog on the goal row gives only one pulse.
- **LFSR:**
  - 8-bit Fibonacci, taps 8,6,5,4; shift-left with feedback into bit 0.
  - Seed 8'hA5. It advances only on a level-up.
- **Simultaneous hit and goal in one cycle:** both are processed independently; hit handling and level-up both take effect.
- `i_Restart` outside OVER has no effect.

## Timing
- **Reset values:**
  - Outputs: `o_Hit`=0, `o_Level_Up`=0, `o_Lives`=`c_LIVES`, `o_Score`=0, `o_Game_Over`=0, `o_Reverse`=0.
  - Internal: state=PLAY, `r_Idx`=0, LFSR=8'hA5, previous-goal register=1. The frog spawning on the goal row therefore does not score.
- **Registered outputs:** all outputs are registered.
  - An overlap compared in cycle t (inputs sampled at t, `r_Idx`=k) gives `o_Hit`, the lives change and the state change at the edge ending t.
  - Worst-case detection latency is `c_NB_CARS` cycles.
- **Goal pulse:** `o_Level_Up` asserts on the edge after the frog-row rising edge is seen. `o_Score` and `o_Reverse` update on the same edge.
- **Grace length:** exactly `c_GRACE_CYCLES` clocks in GRACE.
- **Restart latency:** `i_Restart` in OVER takes effect on the next edge; `o_Game_Over` drops the same edge.
- **Reset priority:** `i_Reset` mid-operation overrides all other events on that edge, including a pending hit or goal.

## Test plan
- **Single hit:** reset with `c_GRACE_CYCLES`=8. Frog row 2, X=100; car 0 X=90. Expect `o_Hit` within 4 cycles and `o_Lives` 3→2. No further `o_Hit` for 8 cycles, then a second hit is accepted (`o_Lives`=1).
- **Edge cases:** car 1 X=132 with frog X=100, row 3 → no hit (touching edge). Car X=131 → hit.
- **Game over and restart:** three separated hits → `o_Lives`=0 and `o_Game_Over`=1. Further overlaps give no `o_Hit`. `i_Restart` → `o_Lives`=3, `o_Score`=0, `o_Reverse`=0, `o_Game_Over`=0.
- **Goal:** frog row 5→0 and held for 100 cycles → exactly one `o_Level_Up`, `o_Score`=1, `o_Reverse`=4'hB (LFSR 8'hA5→8'h4B). Row 0→1→0 → second pulse, `o_Score`=2.
- **Score saturation and reset:** 130 goal entries → `o_Score` holds 127. Assert `i_Reset` in the same cycle as a hit → no `o_Hit`, all outputs at reset values.
